seg_scan_driver: RTL and testbench

Time-multiplexed multi-digit 7-segment driver; next generation of our single-digit BCD/7-segment decoder. Latches a DIGITS-wide packed BCD/hex word, scans one digit per slot, drives shared active-low segments plus active-low digit enables. Keeps lamp-test, blanking and ripple-blanking (leading-zero suppression) across the whole word, adds anti-ghosting guard time. Sits between display-data producers (counters, register files) and board display pins.

---
 rtl/seg_scan_driver.sv | 129 ++++++++++++
 tb/tb_seg_scan_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed DIGITS-wide 7-segment scanner with lamp-test, blanking and leading-zero suppression.
// Optional SEG_HEX_GLYPH_EN: codes 10..15 show hex A-F instead of the legacy decoder glyphs.
module seg_scan_driver #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned GUARD    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  rbi_n,
  input  logic                  bi_n,
  input  logic                  lt_n,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  rbo_n,
  output logic                  scan_tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [6:0]          seg_n_q, seg_n_d;
  logic [DIGITS-1:0]   dig_n_q, dig_n_d;
  logic                rbo_n_q, rbo_n_d;
  logic                scan_tick_q, scan_tick_d;

  logic [3:0]          nib;
  logic                upper_zero;
  logic                suppress;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'b0000001;
      4'd1:    g = 7'b1001111;
      4'd2:    g = 7'b0010010;
      4'd3:    g = 7'b0000110;
      4'd4:    g = 7'b1001100;
      4'd5:    g = 7'b0100100;
      4'd6:    g = 7'b1100000;
      4'd7:    g = 7'b0001111;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0001100;
`ifdef SEG_HEX_GLYPH_EN
      4'd10:   g = 7'b0001000;
      4'd11:   g = 7'b1100000;
      4'd12:   g = 7'b0110001;
      4'd13:   g = 7'b1000010;
      4'd14:   g = 7'b0110000;
      default: g = 7'b0111000;
`else
      4'd10:   g = 7'b1110010;
      4'd11:   g = 7'b1100110;
      4'd12:   g = 7'b1011100;
      4'd13:   g = 7'b0110100;
      4'd14:   g = 7'b1110000;
      default: g = 7'b1111111;
`endif
    endcase
    return g;
  endfunction

  always_comb begin
    shadow_d = load ? din : shadow_q;

    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // Current nibble plus "this and every more-significant nibble is zero" for ripple blanking.
    nib        = '0;
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) nib = shadow_q[4*i +: 4];
      if (i >= 32'(idx_q) && shadow_q[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    suppress = !rbi_n && upper_zero && (idx_q != '0);

    scan_tick_d = (cnt_q == '0);

    dig_n_d = '1;
    if (bi_n && 32'(cnt_q) >= GUARD) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (IDX_W'(i) == idx_q) dig_n_d[i] = 1'b0;
      end
    end

    if (!bi_n)         seg_n_d = '1;
    else if (!lt_n)    seg_n_d = '0;
    else if (suppress) seg_n_d = '1;
    else               seg_n_d = glyph(nib);

    rbo_n_d = !(!rbi_n && shadow_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      seg_n_q     <= '1;
      dig_n_q     <= '1;
      rbo_n_q     <= 1'b1;
      scan_tick_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seg_n_q     <= seg_n_d;
      dig_n_q     <= dig_n_d;
      rbo_n_q     <= rbo_n_d;
      scan_tick_q <= scan_tick_d;
    end
  end

  assign seg_n     = seg_n_q;
  assign dig_n     = dig_n_q;
  assign rbo_n     = rbo_n_q;
  assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, SCAN_DIV=10, GUARD=2).
module tb_seg_scan_driver;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, G6 = 7'b1100000, G7 = 7'b0001111;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0001100, BL = 7'b1111111, LT = 7'b0000000;
`ifdef SEG_HEX_GLYPH_EN
  localparam logic [6:0] GA = 7'b0001000, GB = 7'b1100000, GC = 7'b0110001;
  localparam logic [6:0] GD = 7'b1000010, GE = 7'b0110000, GF = 7'b0111000;
`else
  localparam logic [6:0] GA = 7'b1110010, GB = 7'b1100110, GC = 7'b1011100;
  localparam logic [6:0] GD = 7'b0110100, GE = 7'b1110000, GF = 7'b1111111;
`endif

  typedef struct {
    logic [15:0]     din;
    logic            rbi_n;
    logic            bi_n;
    logic            lt_n;
    logic [3:0][6:0] seg;
    logic            rbo_n;
  } vec_t;

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, load, rbi_n, bi_n, lt_n;
  logic [15:0] din;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        rbo_n, scan_tick;

  int   errors  = 0;
  int   checks  = 0;
  int   exp_idx = 3;
  exp_t sb[$];
  vec_t vt[11];
  logic [6:0] gl [10] = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9};

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(10), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din), .rbi_n(rbi_n), .bi_n(bi_n),
    .lt_n(lt_n), .seg_n(seg_n), .dig_n(dig_n), .rbo_n(rbo_n), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] nib(input logic [15:0] w, input int i);
    return w[4*i +: 4];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_tick !== 1'b1 && n < 40);
    if (scan_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no scan_tick within %0d cycles", n);
    end
    exp_idx = (exp_idx + 1) % 4;
  endtask

  // Lands mid-slot (cnt=5), well past the guard window.
  task automatic sample_slot();
    int n;
    wait_tick(n);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    exp_t       e;
    int         i;
    logic [3:0] one_hot;
    din = v.din; rbi_n = v.rbi_n; bi_n = v.bi_n; lt_n = v.lt_n; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i       = (exp_idx + 1 + k) % 4;
      one_hot = 4'b0001 << i;
      e.seg   = v.seg[i];
      e.dig   = v.bi_n ? ~one_hot : 4'hF;
      sb.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      sample_slot();
      e = sb.pop_front();
      chk($sformatf("v%0d_seg_d%0d", vi, exp_idx), {25'b0, seg_n}, {25'b0, e.seg});
      chk($sformatf("v%0d_dig_d%0d", vi, exp_idx), {28'b0, dig_n}, {28'b0, e.dig});
      if (k == 0) chk($sformatf("v%0d_rbo", vi), {31'b0, rbo_n}, {31'b0, v.rbo_n});
    end
  endtask

  initial begin
    int n;
    int old_idx;
    logic [3:0] oh;

    vt[0]  = '{16'h1234, 1'b1, 1'b1, 1'b1, {G1, G2, G3, G4}, 1'b1};
    vt[1]  = '{16'h0050, 1'b0, 1'b1, 1'b1, {BL, BL, G5, G0}, 1'b1};
    vt[2]  = '{16'h0000, 1'b0, 1'b1, 1'b1, {BL, BL, BL, G0}, 1'b0};
    vt[3]  = '{16'h0000, 1'b1, 1'b1, 1'b1, {G0, G0, G0, G0}, 1'b1};
    vt[4]  = '{16'hABCF, 1'b1, 1'b1, 1'b1, {GA, GB, GC, GF}, 1'b1};
    vt[5]  = '{16'h1234, 1'b1, 1'b0, 1'b0, {BL, BL, BL, BL}, 1'b1};
    vt[6]  = '{16'h1234, 1'b1, 1'b1, 1'b0, {LT, LT, LT, LT}, 1'b1};
    vt[7]  = '{16'h0000, 1'b0, 1'b0, 1'b1, {BL, BL, BL, BL}, 1'b0};
    vt[8]  = '{16'h0E07, 1'b0, 1'b1, 1'b1, {BL, GE, G0, G7}, 1'b1};
    vt[9]  = '{16'h9865, 1'b0, 1'b1, 1'b1, {G9, G8, G6, G5}, 1'b1};
    vt[10] = '{16'h0D00, 1'b0, 1'b1, 1'b1, {BL, GD, G0, G0}, 1'b1};

    rst_n = 1'b0; load = 1'b0; din = '0; rbi_n = 1'b1; bi_n = 1'b1; lt_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg", {25'b0, seg_n}, {25'b0, BL});
    chk("rst_dig", {28'b0, dig_n}, 32'hF);
    chk("rst_rbo", {31'b0, rbo_n}, 32'h1);
    chk("rst_tick", {31'b0, scan_tick}, 32'h0);
    rst_n = 1'b1;
    exp_idx = 3;

    // Guard window then steady tick cadence across idx 0,1,2,3,0.
    wait_tick(n);
    chk("first_tick_lat", n, 1);
    chk("guard_dig_c0", {28'b0, dig_n}, 32'hF);
    @(negedge clk);
    chk("guard_dig_c1", {28'b0, dig_n}, 32'hF);
    @(negedge clk);
    chk("guard_dig_c2", {28'b0, dig_n}, 32'hE);
    wait_tick(n);
    chk("tick_gap_0", n, 8);
    for (int p = 1; p < 4; p++) begin
      wait_tick(n);
      chk($sformatf("tick_gap_%0d", p), n, 10);
    end
    chk("idx_after_5_ticks", exp_idx, 0);

    for (int v = 0; v < 5; v++) run_vec(v, vt[v]);

    // Asynchronous reset in the middle of a slot.
    sample_slot();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", {25'b0, seg_n}, {25'b0, BL});
    chk("midrst_dig", {28'b0, dig_n}, 32'hF);
    chk("midrst_tick", {31'b0, scan_tick}, 32'h0);
    chk("midrst_rbo", {31'b0, rbo_n}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_idx = 3;
    wait_tick(n);
    chk("midrst_tick_lat", n, 1);

    for (int v = 5; v < 11; v++) run_vec(v, vt[v]);

    // Load on the last cycle of a slot: one cycle of old data, then new data on the new digit.
    sample_slot();
    din = 16'h1234; rbi_n = 1'b1; bi_n = 1'b1; lt_n = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_tick(n);
    repeat (8) @(negedge clk);
    old_idx = exp_idx;
    din = 16'h9865; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("bnd_old_seg", {25'b0, seg_n}, {25'b0, gl[nib(16'h1234, old_idx)]});
    chk("bnd_no_tick", {31'b0, scan_tick}, 32'h0);
    @(negedge clk);
    exp_idx = (old_idx + 1) % 4;
    chk("bnd_tick", {31'b0, scan_tick}, 32'h1);
    chk("bnd_new_seg", {25'b0, seg_n}, {25'b0, gl[nib(16'h9865, exp_idx)]});
    chk("bnd_guard_dig", {28'b0, dig_n}, 32'hF);

    // Mid-slot load: two-cycle latency, scan position untouched.
    repeat (3) @(negedge clk);
    din = 16'h0050; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("mid_old_seg", {25'b0, seg_n}, {25'b0, gl[nib(16'h9865, exp_idx)]});
    @(negedge clk);
    chk("mid_new_seg", {25'b0, seg_n}, {25'b0, gl[nib(16'h0050, exp_idx)]});
    oh = 4'b0001 << exp_idx;
    chk("mid_dig", {28'b0, dig_n}, {28'b0, ~oh});

    run_vec(11, vt[9]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
